// File: rtl/pipe_datapath_pkg.sv
// pipe_datapath_pkg: ALU opcodes and instruction field positions shared by the datapath
package pipe_datapath_pkg;
    typedef logic [5:0] alu_op_t;
    localparam alu_op_t ALU_ADD  = 6'b000000;
    localparam alu_op_t ALU_SUB  = 6'b001000;
    localparam alu_op_t ALU_AND  = 6'b000111;
    localparam alu_op_t ALU_OR   = 6'b000110;
    localparam alu_op_t ALU_XOR  = 6'b000100;
    localparam alu_op_t ALU_SLT  = 6'b000010;
    localparam alu_op_t ALU_SLTU = 6'b000011;
    localparam alu_op_t ALU_SLL  = 6'b000001;
    localparam alu_op_t ALU_SRL  = 6'b000101;
    localparam alu_op_t ALU_SRA  = 6'b001101;
    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int IMM_LSB = 20;
    localparam int FIELD_W = 5;
    localparam int IMM_W   = 12;
endpackage

// File: rtl/pipe_datapath_if.sv
// pipe_datapath_if: instruction issue and result retire signals of pipe_datapath
interface pipe_datapath_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           instruction;
    logic [5:0]            ALU_Control;
    logic                  op_B_sel;
    logic                  wEn;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] ALU_result;
    logic [4:0]            out_rd;
    modport master (
        output in_valid, instruction, ALU_Control, op_B_sel, wEn,
        input  in_ready, out_valid, ALU_result, out_rd
    );
    modport slave (
        input  in_valid, instruction, ALU_Control, op_B_sel, wEn,
        output in_ready, out_valid, ALU_result, out_rd
    );
endinterface

// File: rtl/pipe_alu.sv
// pipe_alu: combinational ALU of the execute stage; unknown opcodes yield zero
module pipe_alu
    import pipe_datapath_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  alu_op_t               op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y
);
    localparam int SW = $clog2(DATA_WIDTH);
    logic [SW-1:0] sh;
    assign sh = b[SW-1:0];
    // select the operation result; shifts use only the low bits of b
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_SLT:  y = DATA_WIDTH'($signed(a) < $signed(b));
            ALU_SLTU: y = DATA_WIDTH'(a < b);
            ALU_SLL:  y = a << sh;
            ALU_SRL:  y = a >> sh;
            ALU_SRA:  y = $signed(a) >>> sh;
            default:  y = '0;
        endcase
    end
endmodule

// File: rtl/pipe_datapath.sv
// pipe_datapath: two-stage register-file/ALU datapath; define PIPE_DATAPATH_BYPASS_EN to forward instead of stalling
module pipe_datapath
    import pipe_datapath_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input logic            clock,
    input logic            reset,
    pipe_datapath_if.slave bus
);
    localparam int AW = $clog2(NUM_REGS);
    logic [FIELD_W-1:0]    rs1, rs2, rd, ex_rd;
    logic [AW-1:0]         rs1_idx, rs2_idx, ex_idx;
    logic [IMM_W-1:0]      imm;
    logic [DATA_WIDTH-1:0] imm_ext, rf_a, rf_b, op_a, op_b, ex_a, ex_b, alu_y;
    alu_op_t               ex_ctrl;
    logic                  ex_valid, ex_wen, ex_live, haz_a, haz_b, accept, rst_done;
    logic                  unused_bits;
    assign rs1         = bus.instruction[RS1_LSB +: FIELD_W];
    assign rs2         = bus.instruction[RS2_LSB +: FIELD_W];
    assign rd          = bus.instruction[RD_LSB +: FIELD_W];
    assign imm         = bus.instruction[IMM_LSB +: IMM_W];
    assign unused_bits = ^{bus.instruction[14:12], bus.instruction[6:0], rs1, rs2};
    assign rs1_idx     = rs1[AW-1:0];
    assign rs2_idx     = rs2[AW-1:0];
    assign ex_idx      = ex_rd[AW-1:0];
    assign imm_ext     = DATA_WIDTH'($signed(imm));
    assign ex_live     = ex_valid && ex_wen && ex_idx != '0;
    assign haz_a       = ex_live && ex_idx == rs1_idx;
    assign haz_b       = ex_live && ex_idx == rs2_idx && !bus.op_B_sel;
    if (1) begin : regFile_inst
        logic [DATA_WIDTH-1:0] reg_file [NUM_REGS];
        // write back the retiring result; entry 0 is never written so it reads as zero
        always_ff @(posedge clock or negedge reset)
            if (!reset)
                for (int i = 0; i < NUM_REGS; i++) reg_file[i] <= '0;
            else if (ex_live)
                reg_file[ex_idx] <= alu_y;
    end
    assign rf_a = regFile_inst.reg_file[rs1_idx];
    assign rf_b = regFile_inst.reg_file[rs2_idx];
`ifdef PIPE_DATAPATH_BYPASS_EN
    assign op_a         = haz_a ? alu_y : rf_a;
    assign op_b         = bus.op_B_sel ? imm_ext : haz_b ? alu_y : rf_b;
    assign bus.in_ready = rst_done;
`else
    assign op_a         = rf_a;
    assign op_b         = bus.op_B_sel ? imm_ext : rf_b;
    assign bus.in_ready = rst_done && !haz_a && !haz_b;
`endif
    assign accept = bus.in_valid && bus.in_ready;
    pipe_alu #(.DATA_WIDTH(DATA_WIDTH)) alu_inst (
        .op (ex_ctrl),
        .a  (ex_a),
        .b  (ex_b),
        .y  (alu_y)
    );
    // hold off acceptance until the first edge after reset release
    always_ff @(posedge clock or negedge reset)
        if (!reset)
            rst_done <= 1'b0;
        else
            rst_done <= 1'b1;
    // stage 1: capture operands and controls of the accepted instruction
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            ex_valid <= 1'b0;
            ex_wen   <= 1'b0;
            ex_rd    <= '0;
            ex_ctrl  <= ALU_ADD;
            ex_a     <= '0;
            ex_b     <= '0;
        end else begin
            ex_valid <= accept;
            if (accept) begin
                ex_wen  <= bus.wEn;
                ex_rd   <= rd;
                ex_ctrl <= bus.ALU_Control;
                ex_a    <= op_a;
                ex_b    <= op_b;
            end
        end
    // stage 2: register the ALU result and pulse out_valid once per instruction
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            bus.out_valid  <= 1'b0;
            bus.ALU_result <= '0;
            bus.out_rd     <= '0;
        end else begin
            bus.out_valid <= ex_valid;
            if (ex_valid) begin
                bus.ALU_result <= alu_y;
                bus.out_rd     <= ex_rd;
            end
        end
endmodule
